// File: rtl/df_mac_pe_param.sv
// Dot-product processing element: LEN (x, w) pairs are multiplied, quantised by QDIV and accumulated.
// The accumulator is then saturated to DW bits (optionally ReLU-clipped) and handed out with backpressure.
//
// state | meaning
// IDLE  | waiting for start; len latched, accumulator and pair count cleared on start
// ACC   | accepting pairs until len of them have been taken
// DRAIN | waiting for the product/quotient stages to empty, then registering the result
// OUT   | result held on odata/sat until the downstream handshake
module df_mac_pe_param #(
    parameter int DW      = 16,
    parameter int ACC_W   = 32,
    parameter int QDIV    = 1000,
    parameter int LEN_W   = 10,
    parameter int RELU_EN = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] x,
    input  logic signed [DW-1:0] w,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] odata,
    output logic                 sat,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, OUT} state_t;

    localparam logic signed [2*DW-1:0]  QDIV_S  = (2*DW)'(QDIV);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [DW-1:0]    MAX_DW  = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0]    MIN_DW  = {1'b1, {(DW-1){1'b0}}};

    state_t state, state_next;

    logic [LEN_W-1:0]        len_q;
    logic [LEN_W-1:0]        cnt;
    logic [LEN_W-1:0]        cnt_inc;
    logic signed [2*DW-1:0]  prod;
    logic signed [2*DW-1:0]  p_reg;
    logic signed [ACC_W-1:0] q_reg;
    logic signed [ACC_W-1:0] acc;
    logic                    p_vld;
    logic                    q_vld;
    logic                    accept;
    logic                    start_ok;
    logic                    last_pair;
    logic                    pipe_empty;
    logic signed [DW-1:0]    res;
    logic                    res_sat;

    assign in_ready   = (state == ACC);
    assign out_valid  = (state == OUT);
    assign busy       = (state != IDLE);
    assign accept     = in_ready && in_valid;
    assign start_ok   = (state == IDLE) && start;
    assign cnt_inc    = cnt + LEN_W'(1);
    assign last_pair  = accept && (cnt_inc == len_q);
    assign pipe_empty = !p_vld && !q_vld;

    // DSP multiply is combinational; stage 1 only captures it on an accepted pair.
    assign prod = (2*DW)'(x) * (2*DW)'(w);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = (len == '0) ? DRAIN : ACC;
            ACC:   if (last_pair) state_next = DRAIN;
            DRAIN: if (pipe_empty) state_next = OUT;
            OUT:   if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        res_sat = 1'b0;
        res     = acc[DW-1:0];
        if (acc > SAT_MAX) begin
            res     = MAX_DW;
            res_sat = 1'b1;
        end else if (acc < SAT_MIN) begin
            res     = MIN_DW;
            res_sat = 1'b1;
        end
        // ReLU clips after saturation and does not affect the sat flag.
        if ((RELU_EN != 0) && res[DW-1]) res = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q <= '0;
            cnt   <= '0;
            p_reg <= '0;
            q_reg <= '0;
            acc   <= '0;
            p_vld <= 1'b0;
            q_vld <= 1'b0;
            odata <= '0;
            sat   <= 1'b0;
        end else begin
            p_vld <= accept;
            if (accept) p_reg <= prod;
            q_vld <= p_vld;
            if (p_vld) q_reg <= ACC_W'(p_reg / QDIV_S);
            if (start_ok) begin
                len_q <= len;
                cnt   <= '0;
                acc   <= '0;
            end else begin
                if (q_vld)  acc <= acc + q_reg;
                if (accept) cnt <= cnt_inc;
            end
            if ((state == DRAIN) && pipe_empty) begin
                odata <= res;
                sat   <= res_sat;
            end
        end
    end

endmodule

// File: tb/tb_df_mac_pe_param.sv
// Bench for df_mac_pe_param: a plain and a ReLU instance share all stimulus; results
// are predicted by a reference model into per-instance scoreboards and checked on output.
module tb_df_mac_pe_param;
    localparam int DW = 16, ACC_W = 32, QDIV = 1000, LEN_W = 10;

    logic clk = 1'b0;
    logic rst, start, in_valid, out_ready;
    logic [LEN_W-1:0] len;
    logic signed [DW-1:0] x, w;
    logic in_ready_a, out_valid_a, sat_a, busy_a;
    logic in_ready_r, out_valid_r, sat_r, busy_r;
    logic signed [DW-1:0] odata_a, odata_r;

    typedef struct {longint d; bit s;} exp_t;
    exp_t q_a[$];
    exp_t q_r[$];
    int checks = 0, failures = 0, accepts = 0;
    int px[16], pw[16];

    always #5 clk = ~clk;

    df_mac_pe_param #(.DW(DW), .ACC_W(ACC_W), .QDIV(QDIV), .LEN_W(LEN_W), .RELU_EN(0)) dut_a (
        .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid), .in_ready(in_ready_a),
        .x(x), .w(w), .out_valid(out_valid_a), .out_ready(out_ready), .odata(odata_a),
        .sat(sat_a), .busy(busy_a));

    df_mac_pe_param #(.DW(DW), .ACC_W(ACC_W), .QDIV(QDIV), .LEN_W(LEN_W), .RELU_EN(1)) dut_r (
        .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid), .in_ready(in_ready_r),
        .x(x), .w(w), .out_valid(out_valid_r), .out_ready(out_ready), .odata(odata_r),
        .sat(sat_r), .busy(busy_r));

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: exact product, truncating division, wide sum, then clamp/ReLU.
    task automatic push_exp(input int n);
        longint a = 0;
        longint v;
        bit s = 0;
        for (int i = 0; i < n; i++) a += (longint'(px[i]) * longint'(pw[i])) / QDIV;
        v = a;
        if (a > 32767) begin v = 32767; s = 1; end
        else if (a < -32768) begin v = -32768; s = 1; end
        q_a.push_back('{v, s});
        q_r.push_back('{(v < 0) ? 0 : v, s});
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready_a) accepts++;
            if (out_valid_a) begin
                if (q_a.size() == 0) chk("unexp_out_a", 1, 0);
                else begin
                    chk("odata_a", odata_a, q_a[0].d);
                    chk("sat_a", sat_a, q_a[0].s);
                    if (out_ready) void'(q_a.pop_front());
                end
            end
            if (out_valid_r) begin
                if (q_r.size() == 0) chk("unexp_out_r", 1, 0);
                else begin
                    chk("odata_r", odata_r, q_r[0].d);
                    chk("sat_r", sat_r, q_r[0].s);
                    if (out_ready) void'(q_r.pop_front());
                end
            end
        end
    end

    task automatic wait_idle();
        int g = 0;
        while (busy_a && g < 100) begin tick(); g++; end
        if (busy_a) chk("idle_timeout", busy_a, 0);
    endtask

    task automatic send_pairs(input int n, input bit gaps, input bit stray);
        int i = 0, guard = 0;
        bit acc_now;
        while (i < n && guard < 500) begin
            guard++;
            if (gaps && $urandom_range(0, 2) == 0) in_valid = 1'b0;
            else begin
                in_valid = 1'b1;
                x = DW'(px[i]);
                w = DW'(pw[i]);
            end
            if (stray) begin
                start = 1'($urandom_range(0, 1));
                chk("busy_acc", busy_a, 1);
            end
            acc_now = in_valid && in_ready_a;
            tick();
            if (acc_now) i++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        if (i != n) chk("send_timeout", i, n);
    endtask

    task automatic begin_dot(input int n);
        wait_idle();
        start = 1'b1;
        len = LEN_W'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic run(input int n, input bit gaps, input bit stray);
        begin_dot(n);
        push_exp(n);
        send_pairs(n, gaps, stray);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready_a, 0);
        chk({tag, "_out_valid"}, out_valid_a, 0);
        chk({tag, "_odata"}, odata_a, 0);
        chk({tag, "_sat"}, sat_a, 0);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_busy_r"}, busy_r, 0);
    endtask

    initial begin
        logic signed [DW-1:0] rv;
        int g;
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; out_ready = 1'b1; x = '0; w = '0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Basic dot product with latency check
        px[0] = 1000; pw[0] = 3; px[1] = 2000; pw[1] = 4; px[2] = -500; pw[2] = 7;
        accepts = 0;
        run(3, 0, 0);
        tick(); tick();
        chk("lat_early", out_valid_a, 0);
        tick();
        chk("lat_out", out_valid_a, 1);
        wait_idle();
        chk("basic_accepts", accepts, 3);

        // Positive and negative saturation
        px[0] = 32767; pw[0] = 32767; px[1] = 32767; pw[1] = 32767;
        run(2, 0, 0);
        px[0] = -32768; pw[0] = 32767; px[1] = -32768; pw[1] = 32767;
        run(2, 0, 0);

        // Negative result: -10 plain, 0 through ReLU
        px[0] = -2000; pw[0] = 5;
        run(1, 0, 0);

        // Handshake stress: gaps, stray starts, output stall, start on handshake cycle
        wait_idle();
        for (int i = 0; i < 6; i++) begin
            rv = DW'($urandom); px[i] = rv;
            rv = DW'($urandom); pw[i] = rv;
        end
        out_ready = 1'b0;
        accepts = 0;
        run(6, 1, 1);
        in_valid = 1'b1;
        g = 0;
        while (!out_valid_a && g < 20) begin chk("busy_drain", busy_a, 1); tick(); g++; end
        chk("stress_out_valid", out_valid_a, 1);
        for (int i = 0; i < 5; i++) begin
            start = 1'(i & 1);
            chk("busy_stall", busy_a, 1);
            chk("stall_valid", out_valid_a, 1);
            tick();
        end
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        chk("b2b_start_ignored", busy_a, 0);
        chk("stress_accepts", accepts, 6);

        // Back-to-back run immediately afterwards
        px[0] = 1500; pw[0] = -3; px[1] = 999; pw[1] = 1;
        run(2, 0, 0);

        // len = 0: result 0 without ever raising in_ready
        run(0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("len0_in_ready", in_ready_a, 0);
            tick();
        end
        wait_idle();

        // Reset abort after two of four pairs
        px[0] = 1000; pw[0] = 1; px[1] = 1000; pw[1] = 1;
        begin_dot(4);
        send_pairs(2, 0, 0);
        rst = 1'b1;
        tick();
        chk_reset_outputs("abort");
        rst = 1'b0;
        repeat (8) tick();

        // Fresh run after abort
        px[0] = 1000; pw[0] = 1;
        run(1, 0, 0);
        wait_idle();
        repeat (3) tick();
        chk("sb_empty_a", q_a.size(), 0);
        chk("sb_empty_r", q_r.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/df_mac_pe_param.md
Name: df_mac_pe_param

Overview:
- Parametrised dot-product processing element for the CFNP dataflow array.
- Accepts LEN (x, w) pairs over a valid/ready stream and multiplies each pair in the df DSP slice.
- Each product is quantised by a fixed integer divisor, then accumulated in a wide accumulator.
- Emits one saturated (optionally ReLU-clipped) DW-bit result per dot product, with output backpressure.

Parameters:
- DW, 16: signed width of x, w and odata.
- ACC_W, 32: signed accumulator width; must be >= DW.
- QDIV, 1000: quantisation divisor applied to every product.
- LEN_W, 10: width of the len input.
- RELU_EN, 0: 1 clamps negative results to 0 before output.

Ports:
- clk, input, 1: clock; all logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: one-cycle pulse that begins a dot product and latches len.
- len, input, LEN_W: number of pairs to accumulate; sampled only on an accepted start.
- in_valid, input, 1: x/w pair is valid.
- in_ready, output, 1: PE can accept a pair.
- x, input, DW signed: activation.
- w, input, DW signed: weight.
- out_valid, output, 1: odata is valid.
- out_ready, input, 1: downstream accepts odata.
- odata, output, DW signed: result.
- sat, output, 1: the current odata was saturated; valid while out_valid=1.
- busy, output, 1: state != IDLE.

Behaviour:
- Reset:
  - Outputs: in_ready=0, out_valid=0, odata=0, sat=0, busy=0.
  - Internal: FSM=IDLE; product register, quantise register, accumulator and counters cleared; pipeline valid bits cleared.
  - rst mid-operation aborts the dot product. No partial result is emitted.
- FSM states: IDLE, ACC, DRAIN, OUT.
  - IDLE: start=1 latches len, clears the accumulator and the accepted-count.
    - len=0: go directly to DRAIN; the result is 0.
    - len>0: go to ACC.
  - ACC: in_ready=1. A pair is accepted on any cycle with in_valid & in_ready.
    - On the edge accepting pair number len, go to DRAIN; in_ready drops the next cycle.
    - Gaps in in_valid stall counting only; the pipeline keeps flowing.
  - DRAIN: wait until the pipeline is empty, meaning all stage valid bits are 0. Then register the result into odata/sat and go to OUT.
  - OUT: out_valid=1. odata and sat are held stable until out_valid & out_ready, then return to IDLE.
    - Back-to-back operation is supported: start in the same cycle as the handshake is not accepted; start is accepted one cycle later in IDLE.
- start outside IDLE is ignored. len is not re-sampled.
- Pipeline, per accepted pair:
  - Stage 1: register p = x*w, full 2*DW bits signed.
  - Stage 2: register q = p / QDIV, signed division truncating toward zero (Verilog signed "/"), sign-extended or truncated to ACC_W.
  - Stage 3: acc <= acc + q. Wrap in ACC_W is permitted only if the user exceeds the sizing guarantee; no internal overflow detection.
- Output formation:
  - Saturate acc to [-(2^(DW-1)), 2^(DW-1)-1]. sat=1 if clamping occurred.
  - If RELU_EN=1 and the saturated value is < 0, odata=0. sat reflects only the DW saturation.
- Latency: last pair accepted at edge k → product at k, q at k+1, acc at k+2, odata registered at k+3 → out_valid is high in the cycle after edge k+3 (4 edges).
- in_valid while in_ready=0 is ignored; no pair is consumed.
- The DSP product is combinational from x/w. Stage 1 captures it only on an accepted pair.

Test Plan:
- Basic dot product: len=3; pairs (1000,3), (2000,4), (-500,7) → q = 3, 8, -3 (truncation toward zero); odata=8, sat=0; out_valid 4 edges after the 3rd accept.
- Saturation: len=2; pairs (32767,32767) ×2 → acc=2147352 → odata=32767, sat=1. Repeat with x=-32768, w=32767 → odata=-32768, sat=1.
- ReLU: RELU_EN=1; len=1; pair (-2000,5) → odata=0, sat=0. With RELU_EN=0 the same input gives odata=-10.
- Handshake stress:
  - Stimulus: in_valid toggling randomly; out_ready held low 5 cycles; start pulsed during ACC and during OUT.
  - Required: only len pairs consumed; odata stable while stalled; stray start pulses ignored; busy=1 throughout.
- len=0 plus reset abort:
  - len=0 → out_valid with odata=0, no in_ready assertion.
  - Then start len=4, assert rst after 2 accepts → all outputs return to reset values next cycle.
  - A fresh len=1 run with pair (1000,1) → odata=1.
